// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 slave.
// Optional underrun reporting is enabled with SPI_SLV_UNDERRUN_EN.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_slv_state_e;

  localparam int SPI_DATA_W_DFLT = 8;
  localparam int SPI_SYNC_MIN    = 2;

  // Fewer than two stages would leave the pins metastable-prone.
  function automatic int spi_sync_depth(input int stages);
    return (stages < SPI_SYNC_MIN) ? SPI_SYNC_MIN : stages;
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Host-side word interface of the SPI slave: transmit shadow load and receive word.
interface spi_slave_if import spi_pkg::*; #(
  parameter int DATA_W = SPI_DATA_W_DFLT
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport master (
    output tx_data, tx_load,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_data, tx_load,
    output tx_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for a raw pin, with one-cycle rise/fall events
// taken against the previous synchronised value.
module spi_sync_edge import spi_pkg::*; #(
  parameter int   SYNC_STAGES = SPI_SYNC_MIN,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stage_reg;
  logic [SYNC_STAGES-1:0] stage_next;
  logic                   prev_reg;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_next[gi] = din;
      end else begin : g_rest
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= {SYNC_STAGES{RST_VAL}};
      prev_reg  <= RST_VAL;
    end else begin
      stage_reg <= stage_next;
      prev_reg  <= stage_reg[SYNC_STAGES-1];
    end
  end

  assign sync = stage_reg[SYNC_STAGES-1];
  assign rise = sync & ~prev_reg;
  assign fall = ~sync & prev_reg;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampling sclk/cs_n/mosi in the clk domain (sclk <= clk/4).
// Define SPI_SLV_UNDERRUN_EN to add the sticky tx_underrun flag and err_clr input.
module spi_slave import spi_pkg::*; #(
  parameter int DATA_W      = SPI_DATA_W_DFLT,
  parameter int SYNC_STAGES = SPI_SYNC_MIN
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_slave_if.slave  host,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic        miso_oe
`ifdef SPI_SLV_UNDERRUN_EN
  ,
  input  logic        err_clr,
  output logic        tx_underrun
`endif
);

  localparam int SYNC_N = spi_sync_depth(SYNC_STAGES);
  localparam int CNT_W  = $clog2(DATA_W + 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic unused_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_N), .RST_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .sync  (sclk_sync),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_N), .RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs_n),
    .sync  (cs_sync),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  assign unused_sync = sclk_sync ^ cs_sync;

  // mosi needs the same latency as sclk so the sampled bit lines up with the rise event.
  logic [SYNC_N-1:0] mosi_pipe_reg;
  logic [SYNC_N-1:0] mosi_pipe_next;
  logic              mosi_sync;

  generate
    for (genvar gi = 0; gi < SYNC_N; gi++) begin : g_mosi
      if (gi == 0) begin : g_first
        assign mosi_pipe_next[gi] = mosi;
      end else begin : g_rest
        assign mosi_pipe_next[gi] = mosi_pipe_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_pipe_reg <= '0;
    else        mosi_pipe_reg <= mosi_pipe_next;
  end

  assign mosi_sync = mosi_pipe_reg[SYNC_N-1];

  spi_slv_state_e    state_reg;
  logic [DATA_W-1:0] shadow_reg;
  logic              shadow_full_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic              rx_valid_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              reload_pending_reg;
  logic              miso_reg;
  logic              miso_oe_reg;

  logic              consume;
  logic              load_accept;
  logic [DATA_W-1:0] word_src;
  logic [DATA_W-1:0] shadow_next;
  logic              shadow_full_next;
  logic [DATA_W-1:0] rx_word_next;

  // A word begins at the cs_n fall, and again on the sclk fall after each completed word.
  assign consume = ((state_reg == IDLE) && cs_fall) ||
                   ((state_reg == ACTIVE) && !cs_rise && sclk_fall && reload_pending_reg);

  assign load_accept  = host.tx_load & ~shadow_full_reg;
  assign word_src     = shadow_full_reg ? shadow_reg : '0;
  assign rx_word_next = {rx_shift_reg[DATA_W-2:0], mosi_sync};

  always_comb begin
    shadow_next      = shadow_reg;
    shadow_full_next = shadow_full_reg;
    if (load_accept) begin
      shadow_next      = host.tx_data;
      shadow_full_next = 1'b1;
    end else if (consume) begin
      shadow_full_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      shadow_reg         <= '0;
      shadow_full_reg    <= 1'b0;
      tx_shift_reg       <= '0;
      rx_shift_reg       <= '0;
      rx_data_reg        <= '0;
      rx_valid_reg       <= 1'b0;
      bit_cnt_reg        <= '0;
      reload_pending_reg <= 1'b0;
      miso_reg           <= 1'b0;
      miso_oe_reg        <= 1'b0;
    end else begin
      rx_valid_reg    <= 1'b0;
      shadow_reg      <= shadow_next;
      shadow_full_reg <= shadow_full_next;
      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_reg          <= ACTIVE;
            tx_shift_reg       <= word_src;
            miso_reg           <= word_src[DATA_W-1];
            miso_oe_reg        <= 1'b1;
            bit_cnt_reg        <= '0;
            reload_pending_reg <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // Any partial word is dropped silently.
            state_reg          <= IDLE;
            miso_reg           <= 1'b0;
            miso_oe_reg        <= 1'b0;
            bit_cnt_reg        <= '0;
            reload_pending_reg <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift_reg <= rx_word_next;
            if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
              rx_data_reg        <= rx_word_next;
              rx_valid_reg       <= 1'b1;
              bit_cnt_reg        <= '0;
              reload_pending_reg <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            if (reload_pending_reg) begin
              tx_shift_reg       <= word_src;
              miso_reg           <= word_src[DATA_W-1];
              reload_pending_reg <= 1'b0;
            end else if ((bit_cnt_reg != '0) && (bit_cnt_reg < CNT_W'(DATA_W))) begin
              tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
              miso_reg     <= tx_shift_reg[DATA_W-2];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLV_UNDERRUN_EN
  logic underrun_reg;

  // A new underrun in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          underrun_reg <= 1'b0;
    else if (consume && !shadow_full_reg) underrun_reg <= 1'b1;
    else if (err_clr)                    underrun_reg <= 1'b0;
  end

  assign tx_underrun = underrun_reg;
`endif

  assign host.tx_ready = ~shadow_full_reg;
  assign host.rx_data  = rx_data_reg;
  assign host.rx_valid = rx_valid_reg;
  assign host.busy     = (state_reg == ACTIVE);
  assign miso          = miso_reg;
  assign miso_oe       = miso_oe_reg;

endmodule
